// File: rtl/mux_de_control_carriles_if.sv
// Bundle between the packet source, mux_de_control_carriles and the per-lane
// 8b/10b encoders.
//   in_data    packet beat, lane 0 = [7:0]
//   in_valid   beat valid
//   in_last    last beat of packet (qualified by in_valid)
//   in_ready   block accepts a beat this cycle
//   out_data   symbols to the encoders
//   out_k      per-lane K flag (1 = control symbol)
//   skp_activo high while out_data carries COM or SKP
// master = packet source / encoder side, slave = the framing mux.
interface mux_de_control_carriles_if #(
  parameter int LANES = 4
);
  logic [8*LANES-1:0] in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]   out_k;
  logic               skp_activo;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, out_data, out_k, skp_activo
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, out_data, out_k, skp_activo
  );
endinterface

// File: rtl/mux_de_control_carriles.sv
// Multi-lane framing mux in front of the 8b/10b encoders. Wraps each packet
// in STP ... END K-symbols, fills gaps with PAD, idles with IDL and inserts a
// COM + SKP_LEN x SKP clock-compensation ordered set every SKP_INTERVAL
// cycles, but only between packets.
// Ports:
//   CLK      rising-edge clock
//   reset_L  asynchronous active-low reset
//   bus      slave side of mux_de_control_carriles_if (in_data/in_valid/
//            in_last/in_ready in, out_data/out_k/skp_activo out)
// All outputs except in_ready are registered; in_ready is decoded from the
// state register.
module mux_de_control_carriles #(
  parameter int LANES        = 4,
  parameter int SKP_INTERVAL = 16,
  parameter int SKP_LEN      = 3
) (
  input  logic                        CLK,
  input  logic                        reset_L,
  mux_de_control_carriles_if.slave    bus
);

  localparam int W     = 8 * LANES;
  localparam int CNT_W = $clog2(SKP_INTERVAL + 1);
  localparam int LEN_W = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;
  localparam logic [1:0] S_SKP  = 2'd3;

  // Same symbol on every lane.
  function automatic logic [W-1:0] all_lanes(input logic [7:0] sym);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i +: 8] = sym;
    return r;
  endfunction

  // STP sits in lane 0 so the encoders see the packet start first.
  function automatic logic [W-1:0] stp_word();
    logic [W-1:0] r;
    r       = all_lanes(SYM_PAD);
    r[7:0]  = SYM_STP;
    return r;
  endfunction

  // END sits in the highest lane so it is the last symbol of the frame.
  function automatic logic [W-1:0] end_word();
    logic [W-1:0] r;
    r            = all_lanes(SYM_PAD);
    r[W-1 -: 8]  = SYM_END;
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [W-1:0]     out_data_p0, out_data_d;
  logic [LANES-1:0] out_k_p0, out_k_d;
  logic             skp_activo_p0, skp_activo_d;
  logic             skp_due;

  assign skp_due = (skp_cnt_q == CNT_W'(SKP_INTERVAL));

  always_comb begin
    state_d      = state_q;
    len_cnt_d    = len_cnt_q;
    out_data_d   = all_lanes(SYM_IDL);
    out_k_d      = '1;
    skp_activo_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A due ordered set beats a waiting packet.
        if (skp_due) begin
          out_data_d   = all_lanes(SYM_COM);
          skp_activo_d = 1'b1;
          len_cnt_d    = '0;
          state_d      = S_SKP;
        end else if (bus.in_valid) begin
          out_data_d = stp_word();
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.in_valid) begin
          out_data_d = bus.in_data;
          out_k_d    = '0;
          if (bus.in_last) state_d = S_END;
        end else begin
          out_data_d = all_lanes(SYM_PAD);
        end
      end
      S_END: begin
        out_data_d = end_word();
        state_d    = S_IDLE;
      end
      S_SKP: begin
        out_data_d   = all_lanes(SYM_SKP);
        skp_activo_d = 1'b1;
        if (len_cnt_q == LEN_W'(SKP_LEN - 1)) begin
          len_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Interval counter: frozen at 0 through the whole ordered set, saturates
  // during long packets so the set goes out right after END.
  always_comb begin
    skp_cnt_d = skp_cnt_q;
    if (state_q == S_SKP || (state_q == S_IDLE && skp_due))
      skp_cnt_d = '0;
    else if (!skp_due)
      skp_cnt_d = skp_cnt_q + CNT_W'(1);
  end

  // Stage p0: registered symbol outputs and control state.
  always_ff @(posedge CLK or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= S_IDLE;
      skp_cnt_q     <= '0;
      len_cnt_q     <= '0;
      out_data_p0   <= all_lanes(SYM_IDL);
      out_k_p0      <= '1;
      skp_activo_p0 <= 1'b0;
    end else begin
      state_q       <= state_d;
      skp_cnt_q     <= skp_cnt_d;
      len_cnt_q     <= len_cnt_d;
      out_data_p0   <= out_data_d;
      out_k_p0      <= out_k_d;
      skp_activo_p0 <= skp_activo_d;
    end
  end

  assign bus.in_ready   = (state_q == S_DATA);
  assign bus.out_data   = out_data_p0;
  assign bus.out_k      = out_k_p0;
  assign bus.skp_activo = skp_activo_p0;

endmodule

// File: tb/tb_mux_de_control_carriles.sv
module tb_mux_de_control_carriles;

  localparam logic [31:0] IDL = 32'h7C7C7C7C;
  localparam logic [31:0] STP = 32'hF7F7F7FB;
  localparam logic [31:0] ENDW = 32'hFDF7F7F7;
  localparam logic [31:0] PAD = 32'hF7F7F7F7;
  localparam logic [31:0] COM = 32'hBCBCBCBC;
  localparam logic [31:0] SKP = 32'h1C1C1C1C;

  logic CLK;
  logic reset_L;
  int   n_chk;
  int   n_fail;

  mux_de_control_carriles_if #(.LANES(4)) bus ();

  mux_de_control_carriles #(
    .LANES(4), .SKP_INTERVAL(16), .SKP_LEN(3)
  ) dut (
    .CLK    (CLK),
    .reset_L(reset_L),
    .bus    (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        vld;
    logic        last;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    logic        exp_rdy;
    logic        exp_skp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vld, input logic last, input logic [31:0] din,
                     input logic [31:0] exp_d, input logic [3:0] exp_k,
                     input logic exp_rdy, input logic exp_skp);
    vec_t v;
    v.vld = vld; v.last = last; v.din = din;
    v.exp_d = exp_d; v.exp_k = exp_k; v.exp_rdy = exp_rdy; v.exp_skp = exp_skp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] d, input logic [3:0] k,
                         input logic rdy, input logic skp);
    chk({tag, " out_data"},   bus.out_data, d);
    chk({tag, " out_k"},      {28'd0, bus.out_k}, {28'd0, k});
    chk({tag, " in_ready"},   {31'd0, bus.in_ready}, {31'd0, rdy});
    chk({tag, " skp_activo"}, {31'd0, bus.skp_activo}, {31'd0, skp});
  endtask

  task automatic drive(input logic vld, input logic last, input logic [31:0] din);
    bus.in_valid = vld;
    bus.in_last  = last;
    bus.in_data  = din;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset released 1 time unit after an edge; the next edge is edge 1.
  task automatic do_reset();
    reset_L = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    step();
    reset_L = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_L = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    #12;
    chk_all("reset", IDL, 4'hF, 1'b0, 1'b0);
    step();
    reset_L = 1'b1;

    // Table: edges 1..28 after reset release.
    for (int i = 1; i <= 10; i++) add(0, 0, 32'h0, IDL, 4'hF, 0, 0);        // 1-10 idle
    add(1, 0, 32'h03020100, STP,          4'hF, 1, 0);                     // 11
    add(1, 0, 32'h03020100, 32'h03020100, 4'h0, 1, 0);                     // 12
    add(1, 0, 32'h07060504, 32'h07060504, 4'h0, 1, 0);                     // 13
    add(1, 1, 32'h0B0A0908, 32'h0B0A0908, 4'h0, 0, 0);                     // 14 last
    add(0, 0, 32'h0,        ENDW,         4'hF, 0, 0);                     // 15 END
    add(0, 0, 32'h0,        IDL,          4'hF, 0, 0);                     // 16
    add(1, 0, 32'h11111111, COM,          4'hF, 0, 1);                     // 17 SKP wins
    add(1, 0, 32'h11111111, SKP,          4'hF, 0, 1);                     // 18
    add(1, 0, 32'h11111111, SKP,          4'hF, 0, 1);                     // 19
    add(1, 0, 32'h11111111, SKP,          4'hF, 0, 1);                     // 20
    add(1, 0, 32'h11111111, STP,          4'hF, 1, 0);                     // 21
    add(1, 0, 32'h11111111, 32'h11111111, 4'h0, 1, 0);                     // 22
    add(0, 0, 32'h22222222, PAD,          4'hF, 1, 0);                     // 23 gap
    add(0, 1, 32'h22222222, PAD,          4'hF, 1, 0);                     // 24 gap, stray last
    add(1, 0, 32'h22222222, 32'h22222222, 4'h0, 1, 0);                     // 25
    add(1, 1, 32'h33333333, 32'h33333333, 4'h0, 0, 0);                     // 26 last
    add(0, 0, 32'h0,        ENDW,         4'hF, 0, 0);                     // 27
    add(0, 0, 32'h0,        IDL,          4'hF, 0, 0);                     // 28

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].last, vecs[i].din);
      step();
      chk_all($sformatf("vec%0d", i + 1), vecs[i].exp_d, vecs[i].exp_k,
              vecs[i].exp_rdy, vecs[i].exp_skp);
    end

    // Idle only: COM at 17, SKP 18-20, 16 IDL cycles, COM again at 37.
    do_reset();
    for (int c = 1; c <= 41; c++) begin
      logic [31:0] ed;
      logic        es;
      step();
      if (c == 17 || c == 37) begin ed = COM; es = 1'b1; end
      else if ((c >= 18 && c <= 20) || (c >= 38 && c <= 40)) begin ed = SKP; es = 1'b1; end
      else begin ed = IDL; es = 1'b0; end
      chk($sformatf("idle c%0d out_data", c), bus.out_data, ed);
      chk($sformatf("idle c%0d skp_activo", c), {31'd0, bus.skp_activo}, {31'd0, es});
    end

    // 20-beat packet across the SKP deadline, in_valid held high afterwards.
    do_reset();
    drive(1'b1, 1'b0, 32'hA0000000);
    step();
    chk_all("long stp", STP, 4'hF, 1'b1, 1'b0);
    for (int b = 0; b < 20; b++) begin
      drive(1'b1, (b == 19), 32'hA0000000 + b);
      step();
      chk_all($sformatf("long beat%0d", b), 32'hA0000000 + b, 4'h0, (b != 19), 1'b0);
    end
    drive(1'b1, 1'b0, 32'hC0C0C0C0);
    step();
    chk_all("long end", ENDW, 4'hF, 1'b0, 1'b0);
    step();
    chk_all("long com", COM, 4'hF, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      step();
      chk_all($sformatf("long skp%0d", s), SKP, 4'hF, 1'b0, 1'b1);
    end
    step();
    chk_all("long restart", STP, 4'hF, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0);

    // Asynchronous reset while beat 2 is presented.
    do_reset();
    drive(1'b1, 1'b0, 32'hB0B0B0B0);
    step();
    chk_all("arst stp", STP, 4'hF, 1'b1, 1'b0);
    step();
    chk_all("arst beat0", 32'hB0B0B0B0, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'hB1B1B1B1);
    #2;
    reset_L = 1'b0;
    #1;
    chk_all("arst async", IDL, 4'hF, 1'b0, 1'b0);
    step();
    chk_all("arst held", IDL, 4'hF, 1'b0, 1'b0);
    reset_L = 1'b1;
    step();
    chk_all("arst fresh stp", STP, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'hB1B1B1B1);
    step();
    chk_all("arst beat", 32'hB1B1B1B1, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0);
    step();
    chk_all("arst end", ENDW, 4'hF, 1'b0, 1'b0);
    step();
    chk_all("arst idle", IDL, 4'hF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
